inv_pipe: RTL and testbench
===========================

INV_PIPE -- requirements
Module: inv_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data bits per beat, legal range 1..64.
REQ-002 Parameter DEPTH, default 3: number of register stages, legal range 1..16.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  pipe accepts a beat this cycle.
REQ-007 in_data  input  WIDTH  upstream beat payload.
REQ-008 in_mode  input  1  1 = invert at every stage; 0 = buffer; sampled with the beat.
REQ-009 out_valid  output  1  beat present at the last stage.
REQ-010 out_ready  input  1  downstream takes the beat this cycle.
REQ-011 out_data  output  WIDTH  last-stage payload.
REQ-012 out_mode  output  1  mode bit carried with the beat.
REQ-013 level  output  $clog2(DEPTH+1)  number of occupied stages, 0..DEPTH.

Function
REQ-014 Input transfer occurs on a rising edge with in_valid && in_ready; output transfer on a rising edge with out_valid && out_ready.
REQ-015 Each stage holds valid, data and mode registers; stage k advances when stage k+1 is empty or advancing; the last stage advances when out_ready is high.
REQ-016 in_ready SHALL equal (stage 0 empty) || (stage 0 advancing); it is combinational from out_ready through the stage chain.
REQ-017 On load, stage 0 stores in_data XOR {WIDTH{in_mode}}; stage k stores (stage k-1 data) XOR {WIDTH{stage k-1 mode}}; mode propagates unchanged.
REQ-018 Consequently out_data = in_data XOR {WIDTH{in_mode && DEPTH odd}} for every beat.
REQ-019 Latency: with no stall, a beat accepted on edge N is on out_data with out_valid high after edge N+DEPTH-1.
REQ-020 Throughput: one beat per cycle sustained while out_ready stays high; no bubbles inserted.
REQ-021 Stall: when out_ready is low, occupied stages hold data, mode and valid unchanged; empty stages upstream still fill (bubble collapse).
REQ-022 Full: with level == DEPTH and out_ready low, in_ready SHALL be 0; with out_ready high, in_ready SHALL be 1 (simultaneous pop and push).
REQ-023 Beats SHALL leave in acceptance order; none dropped or duplicated.
REQ-024 level increments on push-only, decrements on pop-only, holds on both or neither.
REQ-025 out_data and out_mode are meaningful only while out_valid is high.
REQ-026 With DEPTH == 1 the block is a single registered skid-free stage obeying REQ-016.

Reset
REQ-027 rst_n low SHALL immediately clear all stage valid, data and mode registers to 0 and level to 0, regardless of clk.
REQ-028 During reset out_valid, out_data, out_mode and level read 0; in_ready reads 1.
REQ-029 Beats in flight at reset assertion are discarded; the first edge after rst_n rises may accept a beat.

Configuration
REQ-030 Macro INV_PIPE_PARITY_EN: when defined, add output out_par (1 bit) = XOR-reduction of the stored stage-0 payload, carried through the stages with the beat and reset to 0.
REQ-031 Without INV_PIPE_PARITY_EN the out_par port and its registers SHALL not exist; all other behaviour is identical.

Verification (WIDTH=8, DEPTH=3)
REQ-032 Reset, then in_data=8'hA5 in_mode=1 single beat, out_ready=1 -> out_valid after edge 3, out_data=8'h5A, out_mode=1, level returns 0.
REQ-033 Stream 8'h00..8'h0F in_mode=0, out_ready=1 -> 16 consecutive out_valid cycles, out_data 8'h00..8'h0F in order, in_ready never low.
REQ-034 Fill with 3 beats, out_ready=0 -> level=3, in_ready=0; then out_ready=1 with in_valid=1 -> one pop and one push per cycle, level stays 3.
REQ-035 Assert rst_n=0 asynchronously mid-stream with level=2 -> out_valid and level 0 before next edge; post-reset beat 8'h3C mode 1 emerges as 8'hC3.
REQ-036 Random in_valid/out_ready toggling, 1000 beats, mixed modes -> scoreboard matches REQ-018 and REQ-023 exactly.
REQ-037 With INV_PIPE_PARITY_EN, beat 8'h01 mode 0 -> out_par=1; beat 8'h03 mode 0 -> out_par=0.

Source files
------------

// File: rtl/inv_pipe.sv
// Elastic register pipeline that optionally inverts the payload at every stage.
// Optional parity sideband enabled by defining INV_PIPE_PARITY_EN.
module inv_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_mode,
`ifdef INV_PIPE_PARITY_EN
    output logic                         out_par,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int LW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] mode;
    logic [DEPTH-1:0] en;
    logic [WIDTH-1:0] data [DEPTH];
    logic             push;
    logic             pop;

    // A stage may load when it is empty or its contents move on downstream.
    // NOTE: blocking '=' is correct here; the chain walks from the last stage back in one pass.
    always_comb begin
        logic take;
        take = out_ready;
        en   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            en[k] = !valid[k] || take;
            take  = en[k];
        end
    end

    assign in_ready  = en[0];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];
    assign out_mode  = mode[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            mode  <= '0;
            // NOTE: payload registers are reset too so outputs read zero during reset.
            for (int k = 0; k < DEPTH; k++) data[k] <= '0;
        end else begin
            if (en[0]) begin
                valid[0] <= in_valid;
                if (in_valid) begin
                    data[0] <= in_data ^ {WIDTH{in_mode}};
                    mode[0] <= in_mode;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (en[k]) begin
                    valid[k] <= valid[k-1];
                    if (valid[k-1]) begin
                        data[k] <= data[k-1] ^ {WIDTH{mode[k-1]}};
                        mode[k] <= mode[k-1];
                    end
                end
            end
        end
    end

`ifdef INV_PIPE_PARITY_EN
    logic [DEPTH-1:0] par;

    // Parity of the stage-0 stored word rides unchanged alongside the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= '0;
        end else begin
            if (en[0] && in_valid) par[0] <= ^(in_data ^ {WIDTH{in_mode}});
            for (int k = 1; k < DEPTH; k++) begin
                if (en[k] && valid[k-1]) par[k] <= par[k-1];
            end
        end
    end

    assign out_par = par[DEPTH-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_pipe.sv
// Directed and randomised self-checking bench for inv_pipe (WIDTH=8, DEPTH=3).
module tb_inv_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic [1:0]       level;
`ifdef INV_PIPE_PARITY_EN
    logic             out_par;
`endif

    int errors = 0;
    int checks = 0;

    inv_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
`ifdef INV_PIPE_PARITY_EN
        .out_par   (out_par),
`endif
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] q[$];
        logic [8:0] exp_beat;
        int sent, got, cyc, lvl;

        // Values while held in reset
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_mode", out_mode, 0);
        #9 rst_n = 1'b1;

        // Single inverted beat: A5 -> 5A after three stages
        in_valid = 1'b1; in_data = 8'hA5; in_mode = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("single_level1", level, 1);
        step();
        check("single_not_yet", out_valid, 0);
        step();
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 8'h5A);
        check("single_mode", out_mode, 1);
        step();
        check("single_level0", level, 0);
        check("single_drained", out_valid, 0);

        // Back-to-back stream 00..0F in buffer mode
        for (int c = 0; c < 18; c++) begin
            in_valid = (c < 16);
            in_data  = 8'(c);
            in_mode  = 1'b0;
            #1;
            if (c < 16) check("stream_in_ready", in_ready, 1);
            step();
            if (c >= 2) begin
                check("stream_valid", out_valid, 1);
                check("stream_data", out_data, 64'(c - 2));
            end else begin
                check("stream_latency", out_valid, 0);
            end
        end
        in_valid = 1'b0;
        step();
        check("stream_level0", level, 0);

        // Fill while stalled, then simultaneous pop and push
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h11; step();
        in_data = 8'h22; step();
        in_data = 8'h33; step();
        in_data = 8'h44; #1;
        check("full_level", level, 3);
        check("full_in_ready", in_ready, 0);
        check("full_head", out_data, 8'h11);
        out_ready = 1'b1; #1;
        check("full_pop_in_ready", in_ready, 1);
        step();
        check("full_swap_level", level, 3);
        check("full_swap_data", out_data, 8'h22);
        in_data = 8'h55; step();
        check("full_swap_level2", level, 3);
        check("full_swap_data2", out_data, 8'h33);
        in_valid = 1'b0; step();
        check("full_drain_data", out_data, 8'h44);
        check("full_drain_level", level, 2);
        step(); step();
        check("full_empty", level, 0);

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h77; in_mode = 1'b1; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_data = 8'h88; step();
        in_valid = 1'b0; step();
        check("pre_rst_level", level, 2);
        check("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_level", level, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h3C; in_mode = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data", out_data, 8'hC3);
        check("post_rst_mode", out_mode, 1);
        step();
        check("post_rst_level", level, 0);

`ifdef INV_PIPE_PARITY_EN
        // Parity of stored payload follows the beat
        in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h01; step();
        in_data = 8'h03; step();
        in_valid = 1'b0; step();
        check("par_valid", out_valid, 1);
        check("par_01", out_par, 1);
        step();
        check("par_03", out_par, 0);
        step();
`endif

        // Random handshakes with a scoreboard
        sent = 0; got = 0; cyc = 0; lvl = 0;
        while (got < 1000 && cyc < 20000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_mode   = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("rand_level", level, lvl);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_spurious", 1, 0);
                end else begin
                    exp_beat = q.pop_front();
                    check("rand_data", out_data, exp_beat[7:0]);
                    check("rand_mode", out_mode, exp_beat[8]);
                end
                got++;
                lvl--;
            end
            if (in_valid && in_ready) begin
                q.push_back({in_mode, in_data ^ {WIDTH{in_mode}}});
                sent++;
                lvl++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rand_received", got, 1000);
        check("rand_queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
